// File: rtl/hist2d_accum_ctrl.sv
// hist2d_accum_ctrl: clears a bin-count RAM, accumulates a programmed number
// of binned shots with a forwarding read-modify-write pipe, then streams every
// bin count followed by the out-of-range count over a valid/ready link.
module hist2d_accum_ctrl #(
    parameter int I_BINS  = 8,
    parameter int Q_BINS  = 8,
    parameter int COUNT_W = 16
) (
    input  logic               clk100,
    input  logic               reset_n,
    input  logic               start,
    input  logic               abort,
    input  logic [15:0]        shot_target,
    input  logic               bin_valid,
    input  logic [5:0]         i_bin_coord,
    input  logic [5:0]         q_bin_coord,
    output logic               bin_ready,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [5:0]         out_i,
    output logic [5:0]         out_q,
    output logic [COUNT_W-1:0] out_count,
    output logic               busy,
    output logic               done
);

    localparam int DEPTH = I_BINS * Q_BINS;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0]      LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [5:0]         I_LIM     = 6'(I_BINS);
    localparam logic [5:0]         Q_LIM     = 6'(Q_BINS);
    localparam logic [5:0]         I_LAST    = 6'(I_BINS - 1);
    localparam logic [5:0]         Q_LAST    = 6'(Q_BINS - 1);
    localparam logic [5:0]         OOR_IDX   = 6'd63;
    localparam logic [COUNT_W-1:0] CNT_MAX   = '1;

    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_ACCUM, S_DRAIN, S_DUMP} state_t;

    // Counters stick at full scale instead of wrapping.
    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + COUNT_W'(1);
    endfunction

    logic [COUNT_W-1:0] mem_q [DEPTH];

    state_t             state_q;
    logic [15:0]        target_q;
    logic [15:0]        shots_q;
    logic [COUNT_W-1:0] oor_q;
    logic [AW-1:0]      clr_addr_q;
    logic               drain_q;
    logic [AW-1:0]      ld_addr_q;
    logic [5:0]         ld_i_q;
    logic [5:0]         ld_qq_q;
    logic               ld_oor_q;
    logic               last_q;
    logic               bin_ready_q;
    logic               out_valid_q;
    logic [5:0]         out_i_q;
    logic [5:0]         out_q_q;
    logic [COUNT_W-1:0] out_count_q;
    logic               busy_q;
    logic               done_q;

    logic               vld_p1_q;
    logic [AW-1:0]      addr_p1_q;
    logic [COUNT_W-1:0] rd_p1_q;
    logic               fwd_vld_q;
    logic [AW-1:0]      fwd_addr_q;
    logic [COUNT_W-1:0] fwd_data_q;

    logic               shot_acc;
    logic               shot_in_range;
    logic [AW-1:0]      shot_addr;
    logic [COUNT_W-1:0] rmw_base_d;
    logic [COUNT_W-1:0] rmw_wdata_d;
    logic               mem_we;
    logic [AW-1:0]      mem_waddr;
    logic [COUNT_W-1:0] mem_wdata;

    assign shot_acc      = bin_valid && bin_ready_q;
    assign shot_in_range = (i_bin_coord < I_LIM) && (q_bin_coord < Q_LIM);
    assign shot_addr     = AW'(q_bin_coord) * AW'(I_BINS) + AW'(i_bin_coord);

    // Stage p2: the read in p1 cannot see the write landing on the same edge,
    // so a matching write from the previous cycle overrides the RAM data.
    assign rmw_base_d  = (fwd_vld_q && (fwd_addr_q == addr_p1_q)) ? fwd_data_q : rd_p1_q;
    assign rmw_wdata_d = sat_inc(rmw_base_d);

    // Single write port shared by the clear sweep and the RMW write-back.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = clr_addr_q;
        mem_wdata = '0;
        if (!abort) begin
            if (state_q == S_CLEAR) begin
                mem_we = 1'b1;
            end else if (vld_p1_q) begin
                mem_we    = 1'b1;
                mem_waddr = addr_p1_q;
                mem_wdata = rmw_wdata_d;
            end
        end
    end

    // Count RAM plus stage p1 read and forwarding registers (data path, no reset).
    always_ff @(posedge clk100) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
        rd_p1_q    <= mem_q[shot_addr];
        addr_p1_q  <= shot_addr;
        fwd_addr_q <= addr_p1_q;
        fwd_data_q <= rmw_wdata_d;
    end

    // Sequencer: clear, accumulate, drain, dump; abort returns to idle at once.
    always_ff @(posedge clk100 or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            target_q    <= '0;
            shots_q     <= '0;
            oor_q       <= '0;
            clr_addr_q  <= '0;
            drain_q     <= 1'b0;
            ld_addr_q   <= '0;
            ld_i_q      <= '0;
            ld_qq_q     <= '0;
            ld_oor_q    <= 1'b0;
            last_q      <= 1'b0;
            bin_ready_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_i_q     <= '0;
            out_q_q     <= '0;
            out_count_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            vld_p1_q    <= 1'b0;
            fwd_vld_q   <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            vld_p1_q  <= 1'b0;
            fwd_vld_q <= vld_p1_q && !abort;
            if (abort) begin
                state_q     <= S_IDLE;
                bin_ready_q <= 1'b0;
                out_valid_q <= 1'b0;
                busy_q      <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start) begin
                            state_q    <= S_CLEAR;
                            busy_q     <= 1'b1;
                            target_q   <= shot_target;
                            shots_q    <= '0;
                            oor_q      <= '0;
                            clr_addr_q <= '0;
                        end
                    end
                    S_CLEAR: begin
                        clr_addr_q <= clr_addr_q + AW'(1);
                        if (clr_addr_q == LAST_ADDR) begin
                            if (target_q == 16'd0) begin
                                state_q     <= S_DUMP;
                                ld_addr_q   <= '0;
                                ld_i_q      <= '0;
                                ld_qq_q     <= '0;
                                ld_oor_q    <= 1'b0;
                                last_q      <= 1'b0;
                                out_valid_q <= 1'b0;
                            end else begin
                                state_q     <= S_ACCUM;
                                bin_ready_q <= 1'b1;
                            end
                        end
                    end
                    // Stage p1 boundary: accepted in-range shots enter the RMW pipe.
                    S_ACCUM: begin
                        if (shot_acc) begin
                            vld_p1_q <= shot_in_range;
                            if (!shot_in_range) begin
                                oor_q <= sat_inc(oor_q);
                            end
                            shots_q <= shots_q + 16'd1;
                            if (shots_q + 16'd1 == target_q) begin
                                bin_ready_q <= 1'b0;
                                state_q     <= S_DRAIN;
                                drain_q     <= 1'b0;
                            end
                        end
                    end
                    S_DRAIN: begin
                        if (drain_q) begin
                            state_q     <= S_DUMP;
                            ld_addr_q   <= '0;
                            ld_i_q      <= '0;
                            ld_qq_q     <= '0;
                            ld_oor_q    <= 1'b0;
                            last_q      <= 1'b0;
                            out_valid_q <= 1'b0;
                        end else begin
                            drain_q <= 1'b1;
                        end
                    end
                    S_DUMP: begin
                        if (out_valid_q && out_ready && last_q) begin
                            out_valid_q <= 1'b0;
                            done_q      <= 1'b1;
                            busy_q      <= 1'b0;
                            state_q     <= S_IDLE;
                        end else if (!out_valid_q || out_ready) begin
                            out_valid_q <= 1'b1;
                            if (ld_oor_q) begin
                                out_i_q     <= OOR_IDX;
                                out_q_q     <= OOR_IDX;
                                out_count_q <= oor_q;
                                last_q      <= 1'b1;
                            end else begin
                                out_i_q     <= ld_i_q;
                                out_q_q     <= ld_qq_q;
                                out_count_q <= mem_q[ld_addr_q];
                                ld_addr_q   <= ld_addr_q + AW'(1);
                                if (ld_i_q == I_LAST) begin
                                    ld_i_q <= '0;
                                    if (ld_qq_q == Q_LAST) begin
                                        ld_oor_q <= 1'b1;
                                    end else begin
                                        ld_qq_q <= ld_qq_q + 6'd1;
                                    end
                                end else begin
                                    ld_i_q <= ld_i_q + 6'd1;
                                end
                            end
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign bin_ready = bin_ready_q;
    assign out_valid = out_valid_q;
    assign out_i     = out_i_q;
    assign out_q     = out_q_q;
    assign out_count = out_count_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_hist2d_accum_ctrl.sv
// Directed bench for hist2d_accum_ctrl: an 8x8 instance with 16-bit counters
// and a lockstep 8x8 instance with 4-bit counters for the saturation case.
module tb_hist2d_accum_ctrl;

    localparam int IB = 8;
    localparam int QB = 8;
    localparam int NB = IB * QB;
    localparam int NW = NB + 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [15:0] shot_target;
    logic        bin_valid;
    logic [5:0]  ic;
    logic [5:0]  qc;
    logic        out_ready;

    logic        bin_ready, out_valid, busy, done;
    logic [5:0]  out_i, out_q;
    logic [15:0] out_count;

    logic        s_bin_ready, s_out_valid, s_busy, s_done;
    logic [5:0]  s_out_i, s_out_q;
    logic [3:0]  s_out_count;

    int n_assert = 0;
    int n_fail   = 0;

    logic [5:0]  got_i [NW];
    logic [5:0]  got_q [NW];
    logic [15:0] got_c [NW];
    logic [3:0]  got_s [NW];
    logic [15:0] exp_c [NB];
    int          n_got;
    int          n_unstable;
    logic        got_to;
    logic [5:0]  si [$];
    logic [5:0]  sq [$];

    always #5 clk = ~clk;

    hist2d_accum_ctrl #(.I_BINS(IB), .Q_BINS(QB), .COUNT_W(16)) u_dut (
        .clk100(clk), .reset_n(rst_n), .start(start), .abort(abort),
        .shot_target(shot_target), .bin_valid(bin_valid),
        .i_bin_coord(ic), .q_bin_coord(qc), .bin_ready(bin_ready),
        .out_valid(out_valid), .out_ready(out_ready), .out_i(out_i),
        .out_q(out_q), .out_count(out_count), .busy(busy), .done(done)
    );

    hist2d_accum_ctrl #(.I_BINS(IB), .Q_BINS(QB), .COUNT_W(4)) u_sat (
        .clk100(clk), .reset_n(rst_n), .start(start), .abort(abort),
        .shot_target(shot_target), .bin_valid(bin_valid),
        .i_bin_coord(ic), .q_bin_coord(qc), .bin_ready(s_bin_ready),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_i(s_out_i),
        .out_q(s_out_q), .out_count(s_out_count), .busy(s_busy), .done(s_done)
    );

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    task automatic clear_exp();
        for (int k = 0; k < NB; k++) exp_c[k] = 16'd0;
    endtask

    task automatic do_start(input logic [15:0] t);
        @(negedge clk);
        start       = 1'b1;
        shot_target = t;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_ready(output int cnt);
        cnt = 1;
        while (!bin_ready && cnt < 300) begin
            @(negedge clk);
            cnt++;
        end
    endtask

    task automatic send_shots();
        for (int k = 0; k < si.size(); k++) begin
            bin_valid = 1'b1;
            ic        = si[k];
            qc        = sq[k];
            @(negedge clk);
        end
        bin_valid = 1'b0;
    endtask

    // mode 0: out_ready held high; mode 1: out_ready high one cycle in three.
    task automatic collect(input int mode);
        logic       prev_stall;
        logic [5:0] pi, pq;
        logic [15:0] pc;
        n_got = 0; n_unstable = 0; got_to = 1'b1; prev_stall = 1'b0;
        pi = '0; pq = '0; pc = '0;
        for (int k = 0; k < NW; k++) begin
            got_i[k] = 'x; got_q[k] = 'x; got_c[k] = 'x; got_s[k] = 'x;
        end
        for (int cyc = 0; cyc < 2000; cyc++) begin
            @(negedge clk);
            if (done) begin
                got_to = 1'b0;
                break;
            end
            if (prev_stall && (out_i !== pi || out_q !== pq || out_count !== pc))
                n_unstable++;
            out_ready = (mode == 0) ? 1'b1 : (cyc % 3 == 2);
            if (out_valid && out_ready) begin
                if (n_got < NW) begin
                    got_i[n_got] = out_i;
                    got_q[n_got] = out_q;
                    got_c[n_got] = out_count;
                    got_s[n_got] = s_out_count;
                end
                n_got++;
            end
            prev_stall = out_valid && !out_ready;
            pi = out_i; pq = out_q; pc = out_count;
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_assert++;
        if ({bin_ready, out_valid, busy, done} !== 4'b0000 || out_i !== 6'd0 ||
            out_q !== 6'd0 || out_count !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got rdy=%b vld=%b busy=%b done=%b i=%0d q=%0d c=%0d, want all 0",
                     bin_ready, out_valid, busy, done, out_i, out_q, out_count);
        end
        n_assert++;
        if ({s_bin_ready, s_out_valid, s_busy, s_done} !== 4'b0000 || s_out_count !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_sat_outputs: got rdy=%b vld=%b busy=%b done=%b c=%0d, want all 0",
                     s_bin_ready, s_out_valid, s_busy, s_done, s_out_count);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int c;
        do_start(16'd4);
        wait_ready(c);
        n_assert++;
        if (c !== 65) begin
            n_fail++;
            $display("FAIL basic_ready_latency: got %0d, want 65", c);
        end
        si = '{6'd1, 6'd2, 6'd2, 6'd63};
        sq = '{6'd0, 6'd3, 6'd3, 6'd5};
        send_shots();
        n_assert++;
        if (bin_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_ready_drop: got %b, want 0", bin_ready);
        end
        collect(0);
        n_assert++;
        if (n_got !== NW || got_to !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_word_count: got %0d words timeout=%b, want 65 timeout=0", n_got, got_to);
        end
        clear_exp();
        exp_c[1]  = 16'd1;
        exp_c[26] = 16'd2;
        for (int k = 0; k < NB; k++) begin
            n_assert++;
            if (got_i[k] !== 6'(k % IB) || got_q[k] !== 6'(k / IB) || got_c[k] !== exp_c[k]) begin
                n_fail++;
                $display("FAIL basic_word %0d: got (%0d,%0d,%0d), want (%0d,%0d,%0d)",
                         k, got_i[k], got_q[k], got_c[k], k % IB, k / IB, exp_c[k]);
            end
        end
        n_assert++;
        if (got_i[NB] !== 6'd63 || got_q[NB] !== 6'd63 || got_c[NB] !== 16'd1) begin
            n_fail++;
            $display("FAIL basic_oor_word: got (%0d,%0d,%0d), want (63,63,1)", got_i[NB], got_q[NB], got_c[NB]);
        end
        @(negedge clk);
        n_assert++;
        if (done !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_after_done: got done=%b busy=%b vld=%b, want 0 0 0", done, busy, out_valid);
        end
    endtask

    task automatic test_back_to_back();
        int c;
        do_start(16'd10);
        wait_ready(c);
        si = {}; sq = {};
        for (int k = 0; k < 10; k++) begin
            si.push_back(6'd7);
            sq.push_back(6'd7);
        end
        send_shots();
        collect(0);
        n_assert++;
        if (got_c[63] !== 16'd10) begin
            n_fail++;
            $display("FAIL hazard_addr63: got %0d, want 10", got_c[63]);
        end
        n_assert++;
        if (got_c[NB] !== 16'd0 || got_c[62] !== 16'd0 || got_c[0] !== 16'd0) begin
            n_fail++;
            $display("FAIL hazard_others: got oor=%0d a62=%0d a0=%0d, want 0 0 0", got_c[NB], got_c[62], got_c[0]);
        end
    endtask

    task automatic test_backpressure();
        int c;
        do_start(16'd3);
        wait_ready(c);
        si = '{6'd0, 6'd7, 6'd63};
        sq = '{6'd0, 6'd7, 6'd63};
        send_shots();
        collect(1);
        n_assert++;
        if (n_unstable !== 0) begin
            n_fail++;
            $display("FAIL bp_stable: got %0d changes while stalled, want 0", n_unstable);
        end
        n_assert++;
        if (n_got !== NW || got_to !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_word_count: got %0d timeout=%b, want 65 timeout=0", n_got, got_to);
        end
        clear_exp();
        exp_c[0]  = 16'd1;
        exp_c[63] = 16'd1;
        for (int k = 0; k < NB; k++) begin
            n_assert++;
            if (got_i[k] !== 6'(k % IB) || got_q[k] !== 6'(k / IB) || got_c[k] !== exp_c[k]) begin
                n_fail++;
                $display("FAIL bp_word %0d: got (%0d,%0d,%0d), want (%0d,%0d,%0d)",
                         k, got_i[k], got_q[k], got_c[k], k % IB, k / IB, exp_c[k]);
            end
        end
        n_assert++;
        if (got_i[NB] !== 6'd63 || got_q[NB] !== 6'd63 || got_c[NB] !== 16'd1) begin
            n_fail++;
            $display("FAIL bp_oor_word: got (%0d,%0d,%0d), want (63,63,1)", got_i[NB], got_q[NB], got_c[NB]);
        end
    endtask

    task automatic test_saturation();
        int c;
        do_start(16'd20);
        wait_ready(c);
        si = {}; sq = {};
        for (int k = 0; k < 20; k++) begin
            si.push_back(6'd0);
            sq.push_back(6'd0);
        end
        send_shots();
        collect(0);
        n_assert++;
        if (got_s[0] !== 4'd15) begin
            n_fail++;
            $display("FAIL sat_4bit: got %0d, want 15", got_s[0]);
        end
        n_assert++;
        if (got_c[0] !== 16'd20) begin
            n_fail++;
            $display("FAIL sat_16bit: got %0d, want 20", got_c[0]);
        end
        n_assert++;
        if (got_s[1] !== 4'd0 || got_s[NB] !== 4'd0) begin
            n_fail++;
            $display("FAIL sat_others: got a1=%0d oor=%0d, want 0 0", got_s[1], got_s[NB]);
        end
    endtask

    task automatic test_zero_target();
        int   c;
        logic saw_ready;
        out_ready = 1'b0;
        do_start(16'd0);
        c = 1;
        saw_ready = bin_ready;
        while (!out_valid && c < 300) begin
            @(negedge clk);
            c++;
            if (bin_ready) saw_ready = 1'b1;
        end
        n_assert++;
        if (c < 65 || c > 67) begin
            n_fail++;
            $display("FAIL zero_dump_latency: got %0d, want 65..67", c);
        end
        collect(0);
        n_assert++;
        if (saw_ready !== 1'b0 || bin_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_bin_ready: got seen=%b, want 0", saw_ready);
        end
        n_assert++;
        if (n_got !== NW) begin
            n_fail++;
            $display("FAIL zero_word_count: got %0d, want 65", n_got);
        end
        for (int k = 0; k < NW; k++) begin
            n_assert++;
            if (got_c[k] !== 16'd0) begin
                n_fail++;
                $display("FAIL zero_word %0d: got %0d, want 0", k, got_c[k]);
            end
        end
    endtask

    task automatic test_abort();
        int   c;
        int   n;
        logic saw_done;
        do_start(16'd2);
        wait_ready(c);
        si = '{6'd3, 6'd0};
        sq = '{6'd4, 6'd0};
        send_shots();
        out_ready = 1'b1;
        n = 0;
        c = 0;
        while (n < 10 && c < 500) begin
            @(negedge clk);
            c++;
            if (out_valid) n++;
        end
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        out_ready = 1'b0;
        n_assert++;
        if (n !== 10 || out_valid !== 1'b0 || busy !== 1'b0 || bin_ready !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_idle: got words=%0d vld=%b busy=%b rdy=%b done=%b, want 10 0 0 0 0",
                     n, out_valid, busy, bin_ready, done);
        end
        saw_done = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (done || out_valid || busy) saw_done = 1'b1;
        end
        n_assert++;
        if (saw_done !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_quiet: got activity=%b after abort, want 0", saw_done);
        end
        do_start(16'd1);
        wait_ready(c);
        si = '{6'd5};
        sq = '{6'd5};
        send_shots();
        collect(0);
        clear_exp();
        exp_c[45] = 16'd1;
        for (int k = 0; k < NB; k++) begin
            n_assert++;
            if (got_i[k] !== 6'(k % IB) || got_q[k] !== 6'(k / IB) || got_c[k] !== exp_c[k]) begin
                n_fail++;
                $display("FAIL rerun_word %0d: got (%0d,%0d,%0d), want (%0d,%0d,%0d)",
                         k, got_i[k], got_q[k], got_c[k], k % IB, k / IB, exp_c[k]);
            end
        end
        n_assert++;
        if (got_c[NB] !== 16'd0 || got_to !== 1'b0) begin
            n_fail++;
            $display("FAIL rerun_oor: got %0d timeout=%b, want 0 timeout=0", got_c[NB], got_to);
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        start       = 1'b0;
        abort       = 1'b0;
        shot_target = 16'd0;
        bin_valid   = 1'b0;
        ic          = 6'd0;
        qc          = 6'd0;
        out_ready   = 1'b0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_backpressure();
        test_saturation();
        test_zero_target();
        test_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/hist2d_accum_ctrl.md
Name: hist2d_accum_ctrl

Overview:
Sequencer that turns the streamed per-shot bin coordinates from the 2D histogram binner into a completed histogram, then reads it out to the host link. It clears an internal count RAM and accumulates a programmed number of shots. It then streams every bin count, followed by the out-of-range count, under a valid/ready handshake. It sits between the hist2d binner (stream_mode=1) and the analysis output mux.

Parameters:
I_BINS, 8, bins along I axis (1..63)
Q_BINS, 8, bins along Q axis (1..63)
COUNT_W, 16, width of each bin counter and of the out-of-range counter

Ports:
clk100  in  1  system clock, 100 MHz
reset_n  in  1  asynchronous active-low reset
start  in  1  pulse; accepted only in IDLE; begins clear+accumulate run
abort  in  1  level; forces return to IDLE from any state next cycle
shot_target  in  16  shots to accumulate; sampled on accepted start; 0 = go straight to DUMP after CLEAR
bin_valid  in  1  coordinate pair present
i_bin_coord  in  6  I bin index (63 = out of range)
q_bin_coord  in  6  Q bin index (63 = out of range)
bin_ready  out  1  high only in ACCUM while shots_seen < shot_target
out_valid  out  1  readout word valid
out_ready  in  1  host accepts word
out_i  out  6  I index of word (63 on final out-of-range word)
out_q  out  6  Q index of word (63 on final word)
out_count  out  COUNT_W  count for that bin
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when final readout word is accepted

Behaviour:
- Reset: state=IDLE; bin_ready, out_valid, busy, done = 0; out_i, out_q, out_count = 0; shots_seen, oor_count = 0. RAM contents undefined until CLEAR.
- Memory: I_BINS*Q_BINS entries of COUNT_W bits; addr = q*I_BINS + i; 1-cycle synchronous read.
- IDLE -> CLEAR on start. CLEAR writes 0 to one address per cycle, ascending, and zeroes oor_count and shots_seen. It lasts exactly I_BINS*Q_BINS cycles, then goes to ACCUM, or to DUMP if shot_target==0.
- ACCUM: a shot is taken when bin_valid && bin_ready. If i_bin_coord>=I_BINS or q_bin_coord>=Q_BINS, oor_count increments and RAM is untouched. Otherwise a 2-stage read-modify-write runs: S1 reads addr, S2 writes value+1.
- RMW hazards: back-to-back shots to the same address forward the S2 write value into S1, so no increment is lost. Sustained 1 shot/cycle is required.
- Saturation: bin and oor counters saturate at 2^COUNT_W-1 and do not wrap.
- When shots_seen reaches shot_target, bin_ready drops in the same cycle the last shot is accepted. The state then goes to DRAIN, which lasts 2 cycles to flush the RMW pipe, then to DUMP.
- DUMP: words go out in address order (i fastest, then q), then one final word with i=q=63 and out_count=oor_count. Total I_BINS*Q_BINS+1 words.
- Output handshake: out_valid rises no later than 2 cycles after DUMP entry. A word transfers on out_valid && out_ready. While out_valid && !out_ready, out_i, out_q and out_count hold stable. The next word may be presented the cycle after a transfer, giving 1 word/cycle when out_ready is held high.
- On transfer of the final word: done pulses for 1 cycle, out_valid drops, and the state goes to IDLE.
- start outside IDLE is ignored. bin_valid outside ACCUM is ignored (bin_ready=0).
- abort: next cycle the state is IDLE, with out_valid, bin_ready and busy low, in-flight RMW discarded, and no done pulse. Abort has priority over simultaneous start.
- reset_n low mid-run behaves as reset, asynchronously.

Test Plan:
- Basic run, I_BINS=Q_BINS=8: start with shot_target=4 and coords (1,0),(2,3),(2,3),(63,5) one per cycle, out_ready=1 -> 65 words. Addr 1 count=1, addr 26 count=2, all others 0, final word (63,63,1), done pulse once.
- Hazard: 10 consecutive cycles of coord (7,7), shot_target=10 -> addr 63 count=10, oor=0.
- Backpressure: toggle out_ready 1-of-3 cycles during DUMP -> word fields stable while stalled; every word appears exactly once and in order.
- Saturation with COUNT_W=4: 20 shots to (0,0) -> count=15.
- shot_target=0 -> CLEAR takes exactly 64 cycles, then DUMP of 65 zero words, bin_ready never high.
- Abort at word 10 of DUMP -> next cycle IDLE, out_valid=0, busy=0, no done. A following start re-clears, and a new run reads all zeros except the new shots.
